clock_gate_ctrl: RTL and testbench

CLOCK_GATE_CTRL -- requirements
Module: clock_gate_ctrl

---
 rtl/clock_pkg.sv | 21 ++
 rtl/clock_cell_gate.sv | 27 ++
 rtl/clock_gate_ctrl.sv | 120 ++++++++++++
 tb/tb_clock_gate_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// ============================================================================
// Module      : clock_pkg
// Description : Shared state encoding and defaults for the clock gate controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package clock_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        COUNT = 2'd1,
        OFF   = 2'd2,
        WAKE  = 2'd3
    } state_t;

    localparam int unsigned WAKE_CYCLES_DEF = 2;

endpackage

`default_nettype wire

// File: rtl/clock_cell_gate.sv
// ============================================================================
// Module      : clock_cell_gate
// Description : Latch-based integrated clock gate; enable captured while ck is low.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module clock_cell_gate (
    input  logic ck,
    input  logic en,
    output logic gck
);

    logic en_lat;

    // Transparent only in the low phase, so gck can never be cut mid-pulse.
    always_latch begin
        if (!ck) begin
            en_lat = en;
        end
    end

    assign gck = ck & en_lat;

endmodule

`default_nettype wire

// File: rtl/clock_gate_ctrl.sv
// ============================================================================
// Module      : clock_gate_ctrl
// Description : Idle-driven clock gating controller; optional gated-cycle
//               statistics counter enabled by CLOCK_GATE_CTRL_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module clock_gate_ctrl
    import clock_pkg::*;
#(
    parameter int unsigned IDLE_W      = 8,
    parameter int unsigned WAKE_CYCLES = WAKE_CYCLES_DEF
) (
    input  logic              ck,
    input  logic              rst,
    input  logic [IDLE_W-1:0] idle_thresh,
    input  logic              active,
    input  logic              force_on,
    input  logic              wake_req,
    output logic              wake_ack,
    output logic              gck,
    output logic              gate_en,
    output logic [15:0]       gated_cycles
);

    localparam logic [IDLE_W-1:0] C_ONE       = {{(IDLE_W-1){1'b0}}, 1'b1};
    localparam logic [3:0]        C_WAKE_LAST = 4'(WAKE_CYCLES - 1);

    state_t            state_q, state_d;
    logic [IDLE_W-1:0] cnt_q, cnt_d;
    logic [3:0]        wcnt_q, wcnt_d;
    logic              gate_en_q;
    logic              wake_ack_q;
    logic              w_wake;

    assign w_wake = active | wake_req | force_on;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wcnt_d  = wcnt_q;
        unique case (state_q)
            RUN: begin
                if (!w_wake && (idle_thresh != '0)) begin
                    state_d = COUNT;
                    cnt_d   = '0;
                end
            end
            COUNT: begin
                // Wake has priority over reaching the threshold.
                if (w_wake || (idle_thresh == '0)) begin
                    state_d = RUN;
                end else if (cnt_q >= (idle_thresh - C_ONE)) begin
                    state_d = OFF;
                end else begin
                    cnt_d = cnt_q + C_ONE;
                end
            end
            OFF: begin
                if (w_wake) begin
                    state_d = WAKE;
                    wcnt_d  = '0;
                end
            end
            WAKE: begin
                if (wcnt_q == C_WAKE_LAST) begin
                    state_d = RUN;
                end else begin
                    wcnt_d = wcnt_q + 4'd1;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge ck) begin
        if (rst) begin
            state_q    <= RUN;
            cnt_q      <= '0;
            wcnt_q     <= '0;
            gate_en_q  <= 1'b1;
            wake_ack_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wcnt_q     <= wcnt_d;
            gate_en_q  <= (state_d != OFF);
            wake_ack_q <= (state_d == RUN) & wake_req;
        end
    end

    assign gate_en  = gate_en_q;
    assign wake_ack = wake_ack_q;

`ifdef CLOCK_GATE_CTRL_STATS_EN
    logic [15:0] gated_q;

    always_ff @(posedge ck) begin
        if (rst) begin
            gated_q <= '0;
        end else if (!gate_en_q && (gated_q != 16'hFFFF)) begin
            gated_q <= gated_q + 16'd1;
        end
    end

    assign gated_cycles = gated_q;
`else
    assign gated_cycles = 16'h0000;
`endif

    clock_cell_gate u_cell_gate (
        .ck  (ck),
        .en  (gate_en_q),
        .gck (gck)
    );

endmodule

`default_nettype wire

// File: tb/tb_clock_gate_ctrl.sv
// ============================================================================
// Module      : tb_clock_gate_ctrl
// Description : Self-checking bench for clock_gate_ctrl (honours CLOCK_GATE_CTRL_STATS_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_clock_gate_ctrl;

    localparam int IDLE_W = 8;
    localparam int WAKE   = 2;

    logic              ck = 1'b0;
    logic              rst;
    logic [IDLE_W-1:0] idle_thresh;
    logic              active;
    logic              force_on;
    logic              wake_req;
    logic              wake_ack;
    logic              gck;
    logic              gate_en;
    logic [15:0]       gated_cycles;

    int n_chk  = 0;
    int n_pass = 0;
    bit started = 1'b0;
    int pulses  = 0;

    clock_gate_ctrl #(.IDLE_W(IDLE_W), .WAKE_CYCLES(WAKE)) dut (
        .ck           (ck),
        .rst          (rst),
        .idle_thresh  (idle_thresh),
        .active       (active),
        .force_on     (force_on),
        .wake_req     (wake_req),
        .wake_ack     (wake_ack),
        .gck          (gck),
        .gate_en      (gate_en),
        .gated_cycles (gated_cycles)
    );

    always #5 ck = ~ck;

    always @(posedge gck) pulses = pulses + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (act !== exp) begin
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end else begin
            n_pass = n_pass + 1;
        end
    endtask

    // Model: gating follows from run-lengths of idle edges and a wake countdown.
    int m_idle      = 0;
    bit m_off       = 1'b0;
    int m_wake_left = 0;
    bit m_gate      = 1'b1;
    bit m_ack       = 1'b0;
    int m_gated     = 0;
    bit m_prev_gate;
    bit m_wake;

    always @(posedge ck) begin
        if (rst) begin
            m_idle = 0; m_off = 1'b0; m_wake_left = 0;
            m_gate = 1'b1; m_ack = 1'b0; m_gated = 0;
        end else begin
            m_prev_gate = m_gate;
            m_wake      = active | wake_req | force_on;
            if (m_off) begin
                if (m_wake) begin
                    m_off = 1'b0;
                    m_wake_left = WAKE;
                end
            end else if (m_wake_left > 0) begin
                m_wake_left = m_wake_left - 1;
                m_idle = 0;
            end else if (m_wake || idle_thresh == 0) begin
                m_idle = 0;
            end else begin
                m_idle = m_idle + 1;
                if (m_idle >= int'(idle_thresh) + 1) begin
                    m_off  = 1'b1;
                    m_idle = 0;
                end
            end
            m_gate = !m_off;
            m_ack  = wake_req && !m_off && m_wake_left == 0 && m_idle == 0;
`ifdef CLOCK_GATE_CTRL_STATS_EN
            if (!m_prev_gate && m_gated < 65535) m_gated = m_gated + 1;
`endif
        end
    end

    always @(negedge ck) begin
        if (started) begin
            chk("model gate_en", {31'd0, gate_en}, {31'd0, m_gate});
            chk("model wake_ack", {31'd0, wake_ack}, {31'd0, m_ack});
            chk("model gated_cycles", {16'd0, gated_cycles}, m_gated);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge ck);
        #1;
    endtask

    initial begin
        int p0;
        int offcnt;
        rst = 1'b1; active = 1'b1; force_on = 1'b0; wake_req = 1'b0; idle_thresh = 8'd4;
        tick(1);
        started = 1'b1;
        tick(2);
        chk("reset gate_en", {31'd0, gate_en}, 32'd1);
        chk("reset wake_ack", {31'd0, wake_ack}, 32'd0);
        chk("reset gated_cycles", {16'd0, gated_cycles}, 32'd0);
        rst = 1'b0;
        tick(3);

        // Threshold 4: active drops at edge e, gate closes from e+5.
        tick(1); active = 1'b0;
        tick(4);
        chk("idle gate still on at e+4", {31'd0, gate_en}, 32'd1);
        tick(1);
        chk("idle gate off at e+5", {31'd0, gate_en}, 32'd0);
        p0 = pulses;
        tick(10);
        chk("no gck pulses while off", pulses - p0, 32'd0);

        // Wake request from OFF.
        wake_req = 1'b1;
        tick(1);
        chk("wake gate_en on", {31'd0, gate_en}, 32'd1);
        chk("wake ack low in WAKE 1", {31'd0, wake_ack}, 32'd0);
        tick(1);
        chk("wake ack low in WAKE 2", {31'd0, wake_ack}, 32'd0);
        tick(1);
        chk("wake ack in RUN", {31'd0, wake_ack}, 32'd1);
        wake_req = 1'b0;
        tick(1);
        chk("wake ack drops", {31'd0, wake_ack}, 32'd0);
        active = 1'b1;
        tick(2);

        // Active pulse coincides with threshold: wake wins.
        tick(1); active = 1'b0; p0 = pulses;
        tick(4); active = 1'b1;
        tick(1); active = 1'b0;
        chk("race gate stays on", {31'd0, gate_en}, 32'd1);
        tick(1);
        chk("race gate on e+6", {31'd0, gate_en}, 32'd1);
        chk("race no lost gck pulse", pulses - p0, 32'd6);
        active = 1'b1;
        tick(2);

        // Threshold 0 disables gating.
        idle_thresh = 8'd0; active = 1'b0; offcnt = 0; p0 = pulses;
        repeat (100) begin
            tick(1);
            if (gate_en !== 1'b1) offcnt = offcnt + 1;
        end
        chk("thresh0 never gated", offcnt, 32'd0);
        chk("thresh0 gck pulses", pulses - p0, 32'd100);

        // Reset while OFF.
        idle_thresh = 8'd2;
        tick(5);
        chk("pre-reset gate off", {31'd0, gate_en}, 32'd0);
        rst = 1'b1;
        tick(1);
        chk("rst-in-off gate_en", {31'd0, gate_en}, 32'd1);
        chk("rst-in-off wake_ack", {31'd0, wake_ack}, 32'd0);
        chk("rst-in-off gated_cycles", {16'd0, gated_cycles}, 32'd0);
        rst = 1'b0; p0 = pulses;
        tick(2);
        chk("gck resumes after reset", pulses - p0, 32'd2);
        tick(1);
        chk("regated after reset", {31'd0, gate_en}, 32'd0);

        // Statistics counter.
`ifdef CLOCK_GATE_CTRL_STATS_EN
        tick(70000);
        chk("stats saturate", {16'd0, gated_cycles}, 32'd65535);
`else
        tick(300);
        chk("stats tied off", {16'd0, gated_cycles}, 32'd0);
`endif

        started = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
